// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_pkg
//  Purpose  : Shared constants, width typedefs and helpers for the dff cell
//             and the blocks that instantiate it.
//  Revision : 1.0  initial release
// ============================================================================
package dff_pkg;

  // Tie-off values for the stall and clear pins of dff.
  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Legal data width range of dff.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 1024;

  // Common width typedefs for registers built from dff.
  typedef logic [0:0]  bit1_t;
  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  // Example state type for a small FSM whose state register is a tied-off dff.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

  // Which update rule applies on a given edge, in priority order.
  typedef enum logic [1:0] {
    BR_RESET = 2'd0,
    BR_CLEAR = 2'd1,
    BR_STALL = 2'd2,
    BR_LOAD  = 2'd3
  } dff_branch_e;

  // Resolve the control pins into the single winning update rule.
  function automatic dff_branch_e dff_branch(input logic a_rst,
                                             input logic a_clear,
                                             input logic a_stall);
    dff_branch_e br;
    if (a_rst) begin
      br = BR_RESET;
    end else if (a_clear) begin
      br = BR_CLEAR;
    end else if (a_stall) begin
      br = BR_STALL;
    end else begin
      br = BR_LOAD;
    end
    return br;
  endfunction

endpackage : dff_pkg
`default_nettype wire

// File: rtl/dff_if.sv
`default_nettype none
// ============================================================================
//  Module   : dff_if
//  Purpose  : Bundle of the control/data signals around one dff instance.
//             The master side drives rst/stall/clear/d, the slave returns q.
//  Revision : 1.0  initial release
// ============================================================================
interface dff_if #(
  parameter int WIDTH = 1
) (
  input logic clk
);

  logic             rst;
  logic             stall;
  logic             clear;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (
    input  clk,
    input  q,
    output rst,
    output stall,
    output clear,
    output d
  );

  modport slave (
    input  clk,
    input  rst,
    input  stall,
    input  clear,
    input  d,
    output q
  );

endinterface : dff_if
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
//  Module   : dff
//  Purpose  : WIDTH-bit register with synchronous reset, clear (flush) and
//             stall (hold). Priority per edge: rst, clear, stall, load.
//             Port order is fixed so positional instantiations keep binding.
//  Revision : 1.0  initial release
// ============================================================================
module dff
  import dff_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             stall,
  input  wire logic             clear,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  // Reject an unusable width at elaboration rather than building a broken cell.
  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("dff: WIDTH=%0d outside legal range %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  logic [WIDTH-1:0] r_q;
  dff_branch_e      w_branch;

  // Resolve the control pins once so the register and the checks agree.
  always_comb begin
    w_branch = dff_branch(rst, clear, stall);
  end

  // Single state register; every bit moves together, no per-bit enable.
  always_ff @(posedge clk) begin
    case (w_branch)
      BR_RESET: r_q <= INIT;
      BR_CLEAR: r_q <= INIT;
      BR_STALL: r_q <= r_q;
      BR_LOAD:  r_q <= d;
      default:  r_q <= r_q;
    endcase
  end

  // Output comes straight from the flops; no input reaches q combinationally.
  assign q = r_q;

`ifndef SYNTHESIS
  // Control pins must be known whenever reset is not masking them.
  a_ctrl_known: assert property (@(posedge clk) !rst |-> !$isunknown({stall, clear}))
    else $error("dff: X/Z on stall or clear outside reset");

  // Reset always lands on INIT regardless of the other pins.
  a_reset: assert property (@(posedge clk) rst |=> (q === INIT))
    else $error("dff: reset did not load INIT");

  // Clear beats stall and load.
  a_clear: assert property (@(posedge clk) (!rst && clear) |=> (q === INIT))
    else $error("dff: clear did not load INIT");

  // Clear and stall together still flush.
  a_clear_over_stall: assert property (@(posedge clk) (!rst && clear && stall) |=> (q === INIT))
    else $error("dff: clear did not win over stall");

  // Stall holds the current value.
  a_stall: assert property (@(posedge clk) (!rst && !clear && stall) |=> (q === $past(q)))
    else $error("dff: stall did not hold q");

  // Plain load is exactly one cycle of latency.
  a_load: assert property (@(posedge clk) (!rst && !clear && !stall) |=> (q === $past(d)))
    else $error("dff: load did not capture d");

  // One cover per priority branch, plus the clear-over-stall overlap.
  c_reset:       cover property (@(posedge clk) rst);
  c_clear:       cover property (@(posedge clk) !rst && clear);
  c_clear_stall: cover property (@(posedge clk) !rst && clear && stall);
  c_stall:       cover property (@(posedge clk) !rst && !clear && stall);
  c_load:        cover property (@(posedge clk) !rst && !clear && !stall);
`endif

endmodule : dff
`default_nettype wire

// File: tb/tb_dff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff
//  Purpose  : Directed and random checks of dff at widths 1, 8 and 32.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff;
  import dff_pkg::*;

  localparam logic [7:0]  c_INIT_A = 8'hA5;
  localparam logic [7:0]  c_INIT_Z = 8'h00;
  localparam logic [31:0] c_INIT_W = 32'h1234_5678;

  logic clk;
  int   n_cmp;
  int   n_err;

  dff_if #(.WIDTH(8))  if8a (.clk(clk));
  dff_if #(.WIDTH(8))  if8z (.clk(clk));
  dff_if #(.WIDTH(1))  if1  (.clk(clk));
  dff_if #(.WIDTH(32)) if32 (.clk(clk));

  dff #(.WIDTH(8), .INIT(c_INIT_A)) u_dff8a (
    .clk(clk), .rst(if8a.rst), .stall(if8a.stall), .clear(if8a.clear), .d(if8a.d), .q(if8a.q));
  dff #(.WIDTH(8), .INIT(c_INIT_Z)) u_dff8z (
    .clk(clk), .rst(if8z.rst), .stall(if8z.stall), .clear(if8z.clear), .d(if8z.d), .q(if8z.q));
  dff #(.WIDTH(1), .INIT(1'b0)) u_dff1 (
    .clk(clk), .rst(if1.rst), .stall(if1.stall), .clear(if1.clear), .d(if1.d), .q(if1.q));
  dff #(.WIDTH(32), .INIT(c_INIT_W)) u_dff32 (
    .clk(clk), .rst(if32.rst), .stall(if32.stall), .clear(if32.clear), .d(if32.d), .q(if32.q));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    n_cmp++; if (if8a.q !== c_INIT_A) begin n_err++; $display("FAIL reset_8a: got %h want %h", if8a.q, c_INIT_A); end
    n_cmp++; if (if8z.q !== c_INIT_Z) begin n_err++; $display("FAIL reset_8z: got %h want %h", if8z.q, c_INIT_Z); end
    n_cmp++; if (if1.q !== 1'b0) begin n_err++; $display("FAIL reset_1: got %b want 0", if1.q); end
    n_cmp++; if (if32.q !== c_INIT_W) begin n_err++; $display("FAIL reset_32: got %h want %h", if32.q, c_INIT_W); end
    if8a.rst = 1'b0; if8z.rst = 1'b0; if1.rst = 1'b0; if32.rst = 1'b0;
    if8a.d = 8'h3C;
    n_cmp++; if (if8a.q !== c_INIT_A) begin n_err++; $display("FAIL load_before_edge: got %h want %h", if8a.q, c_INIT_A); end
    step();
    n_cmp++; if (if8a.q !== 8'h3C) begin n_err++; $display("FAIL load_3c: got %h want 3c", if8a.q); end
  endtask

  task automatic test_stall();
    logic [7:0] dv [3];
    dv[0] = 8'h22; dv[1] = 8'h33; dv[2] = 8'h44;
    if8z.d = 8'h11;
    step();
    n_cmp++; if (if8z.q !== 8'h11) begin n_err++; $display("FAIL stall_load11: got %h want 11", if8z.q); end
    if8z.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if8z.d = dv[i];
      step();
      n_cmp++; if (if8z.q !== 8'h11) begin n_err++; $display("FAIL stall_hold%0d: got %h want 11", i, if8z.q); end
    end
    if8z.stall = 1'b0;
    if8z.d = 8'h55;
    step();
    n_cmp++; if (if8z.q !== 8'h55) begin n_err++; $display("FAIL stall_release: got %h want 55", if8z.q); end
    // Reset landing in the middle of a stall.
    if8z.stall = 1'b1; if8z.rst = 1'b1; if8z.d = 8'hEE;
    step();
    n_cmp++; if (if8z.q !== c_INIT_Z) begin n_err++; $display("FAIL stall_reset: got %h want %h", if8z.q, c_INIT_Z); end
    if8z.stall = 1'b0; if8z.rst = 1'b0;
  endtask

  task automatic test_clear_stall();
    if8z.d = 8'h7E;
    step();
    n_cmp++; if (if8z.q !== 8'h7E) begin n_err++; $display("FAIL clr_load7e: got %h want 7e", if8z.q); end
    if8z.clear = 1'b1; if8z.stall = 1'b1; if8z.d = 8'hFF;
    step();
    n_cmp++; if (if8z.q !== c_INIT_Z) begin n_err++; $display("FAIL clr_over_stall: got %h want %h", if8z.q, c_INIT_Z); end
    if8z.clear = 1'b0; if8z.stall = 1'b0;
  endtask

  task automatic test_tieoff();
    logic       dv [5];
    logic       rv [5];
    logic       ev [5];
    if1.stall = FALSE; if1.clear = DISABLE;
    dv[0] = 1'b1; rv[0] = 1'b0; ev[0] = 1'b1;
    dv[1] = 1'b0; rv[1] = 1'b0; ev[1] = 1'b0;
    dv[2] = 1'b1; rv[2] = 1'b0; ev[2] = 1'b1;
    dv[3] = 1'b1; rv[3] = 1'b1; ev[3] = 1'b0;
    dv[4] = 1'b1; rv[4] = 1'b0; ev[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if1.d = dv[i]; if1.rst = rv[i];
      step();
      n_cmp++; if (if1.q !== ev[i]) begin n_err++; $display("FAIL tieoff_%0d: got %b want %b", i, if1.q, ev[i]); end
    end
    if1.rst = 1'b0;
  endtask

  task automatic test_sync_reset();
    if32.d = 32'hCAFE_F00D;
    step();
    n_cmp++; if (if32.q !== 32'hCAFE_F00D) begin n_err++; $display("FAIL w_load: got %h want cafef00d", if32.q); end
    if32.rst = 1'b1;
    #3;
    n_cmp++; if (if32.q !== 32'hCAFE_F00D) begin n_err++; $display("FAIL w_rst_between_edges: got %h want cafef00d", if32.q); end
    step();
    n_cmp++; if (if32.q !== c_INIT_W) begin n_err++; $display("FAIL w_rst_edge: got %h want %h", if32.q, c_INIT_W); end
    if32.rst = 1'b0; if32.d = 32'hFFFF_0000;
    step();
    n_cmp++; if (if32.q !== 32'hFFFF_0000) begin n_err++; $display("FAIL w_resume: got %h want ffff0000", if32.q); end
    if32.rst = 1'b1; if32.clear = 1'b1; if32.d = 32'h0BAD_0BAD;
    step();
    n_cmp++; if (if32.q !== c_INIT_W) begin n_err++; $display("FAIL w_rst_clear: got %h want %h", if32.q, c_INIT_W); end
    if32.rst = 1'b0; if32.clear = 1'b0;
  endtask

  task automatic test_x_under_reset();
    if8a.d = 8'h5A;
    step();
    n_cmp++; if (if8a.q !== 8'h5A) begin n_err++; $display("FAIL x_preload: got %h want 5a", if8a.q); end
    if8a.rst = 1'b1; if8a.stall = 1'bx; if8a.clear = 1'bz;
    step();
    n_cmp++; if (if8a.q !== c_INIT_A) begin n_err++; $display("FAIL x_in_reset: got %h want %h", if8a.q, c_INIT_A); end
    if8a.rst = 1'b0; if8a.stall = 1'b0; if8a.clear = 1'b0; if8a.d = 8'h99;
    step();
    n_cmp++; if (if8a.q !== 8'h99) begin n_err++; $display("FAIL x_after_reset: got %h want 99", if8a.q); end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    int         hits [4];
    int         r;
    for (int k = 0; k < 4; k++) hits[k] = 0;
    if8a.rst = 1'b1;
    step();
    exp = c_INIT_A;
    n_cmp++; if (if8a.q !== exp) begin n_err++; $display("FAIL rnd_start: got %h want %h", if8a.q, exp); end
    for (int i = 0; i < 10000; i++) begin
      r = int'($urandom_range(0, 99));
      if8a.rst   = (r < 5);
      r = int'($urandom_range(0, 99));
      if8a.clear = (r < 10);
      r = int'($urandom_range(0, 99));
      if8a.stall = (r < 35);
      if8a.d     = 8'($urandom);
      if (if8a.rst) begin
        exp = c_INIT_A; hits[0]++;
      end else if (if8a.clear) begin
        exp = c_INIT_A; hits[1]++;
      end else if (if8a.stall) begin
        hits[2]++;
      end else begin
        exp = if8a.d; hits[3]++;
      end
      step();
      n_cmp++;
      if (if8a.q !== exp) begin
        n_err++;
        $display("FAIL rnd_cycle%0d: got %h want %h", i, if8a.q, exp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (hits[k] == 0) begin n_err++; $display("FAIL rnd_branch%0d_hit: got 0 want >0", k); end
    end
    if8a.rst = 1'b0; if8a.clear = 1'b0; if8a.stall = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    if8a.rst = 1'b1; if8a.stall = 1'b0; if8a.clear = 1'b0; if8a.d = '0;
    if8z.rst = 1'b1; if8z.stall = 1'b0; if8z.clear = 1'b0; if8z.d = '0;
    if1.rst  = 1'b1; if1.stall  = 1'b0; if1.clear  = 1'b0; if1.d  = '0;
    if32.rst = 1'b1; if32.stall = 1'b0; if32.clear = 1'b0; if32.d = '0;
    test_reset();
    test_stall();
    test_clear_stall();
    test_tieoff();
    test_sync_reset();
    test_x_under_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dff
`default_nettype wire

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter: WIDTH, default 1, data width in bits; legal range 1..1024.
REQ-002 Parameter: INIT, default 0 (WIDTH bits), value loaded by reset and by clear.
REQ-003 The port order SHALL be clk, rst, stall, clear, d, q, so that existing positional instantiations bind unchanged.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 stall  input  1  when high, q holds its current value.
REQ-007 clear  input  1  when high, q returns to INIT on the next edge (flush).
REQ-008 d  input  WIDTH  next-state data.
REQ-009 q  output  WIDTH  registered state, driven directly from flops.

Function
REQ-010 The update at each rising clk edge SHALL follow a fixed priority: rst, then clear, then stall, then load.
- rst=1: q <= INIT.
- else clear=1: q <= INIT.
- else stall=1: q holds.
- else: q <= d.
REQ-011 Latency SHALL be exactly one cycle from d to q when loading; there is no combinational path from any input to q.
REQ-012 When clear and stall are both high, clear SHALL win and q SHALL become INIT.
REQ-013 A stall held for N cycles SHALL hold q for N edges; q SHALL reload d on the first edge with stall=0.
REQ-014 All WIDTH bits SHALL update together; there is no partial-bit enable.
REQ-015 The constant-disable tie-off (stall=0, clear=0) SHALL behave as a plain D register with synchronous reset, for use as an FSM state register.
REQ-016 X/Z on stall or clear while rst=1 SHALL NOT affect q.
REQ-017 An X on stall or clear outside reset SHALL be flagged by a simulation-only assertion; it SHALL NOT be silently ignored.

Reset
REQ-018 Reset SHALL be synchronous: asserting rst between edges does not change q until the next rising edge.
REQ-019 On the first edge with rst=1, q SHALL equal INIT.
REQ-020 Reset asserted mid-stall or mid-clear SHALL still yield INIT.
REQ-021 After rst deasserts, normal priority SHALL resume on the next edge.
REQ-022 q before the first reset edge is undefined; no asynchronous or initial-block value is permitted.

Structure
REQ-023 The shared package SHALL hold the TRUE/FALSE and ENABLE/DISABLE 1-bit constants used to tie off stall and clear, plus any width typedefs (for example, state types of FSMs that instantiate dff).
REQ-024 dff is a leaf cell with no sub-modules.
REQ-025 The implementation SHALL contain:
- an elaboration-time parameter check rejecting WIDTH<1;
- simulation-only assertions for REQ-010, REQ-012 and REQ-017;
- cover points for each priority branch.

Verification
REQ-026 WIDTH=8, INIT=8'hA5: rst=1 for 1 edge -> q=A5; rst=0, d=3C -> q=3C after 1 edge.
REQ-027 WIDTH=8: load 11, then stall=1 for 3 edges with d=22,33,44 -> q stays 11; stall=0 with d=55 -> q=55 on the next edge.
REQ-028 WIDTH=8, INIT=00: q=7E; clear=1 and stall=1 together for 1 edge -> q=00.
REQ-029 WIDTH=1, stall=0, clear=0 (FSM tie-off): d toggles 1,0,1 -> q follows one cycle later; a rst pulse mid-sequence -> q=0 (INIT) on that edge.
REQ-030 WIDTH=32: assert rst between edges -> q unchanged until the next rising edge; clear=1 with rst=1 -> q=INIT.
REQ-031 Random stimulus over 10k cycles, compared against a reference model of REQ-010 -> zero mismatches, and every priority cover point hit.
